// File: rtl/tid_retire_tracker.sv
// Retirement tracker for CGRA thread launches: bitmap of retired TIDs, in-order watermark and done.
// Optional idle watchdog compiled in with `define RETIRE_TIMEOUT_EN.
module tid_retire_tracker #(
  parameter int unsigned TOTAL_TID      = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned TW             = $clog2(TOTAL_TID + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable,
  input  logic          clr,
  input  logic [TW-1:0] max_tid,
  input  logic          retire_valid,
  input  logic [TW-1:0] retire_tid,
  output logic          retire_ready,
  output logic [TW-1:0] retired_count,
  output logic [TW-1:0] commit_tid,
  output logic          done,
  output logic          dup_err,
  output logic          range_err,
  output logic          timeout
);

  localparam int unsigned IW = (TOTAL_TID > 1) ? $clog2(TOTAL_TID) : 1;
  localparam logic [TW-1:0] MaxLegal = TW'(TOTAL_TID - 1);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e               state_q, state_d;
  logic [TOTAL_TID-1:0] bitmap_q, bitmap_d;
  logic [TW-1:0]        max_q, max_d;
  logic [TW-1:0]        count_q, count_d;
  logic [TW-1:0]        commit_q, commit_d;
  logic                 done_q, done_d;
  logic                 dup_q, dup_d;
  logic                 range_q, range_d;

  logic          accept;
  logic          commit_hit;
  logic [IW-1:0] tid_idx;
  logic [IW-1:0] commit_idx;

  assign retire_ready = (state_q == StActive) && enable;
  // clr wins over a coincident notification
  assign accept       = retire_valid && retire_ready && !clr;
  assign tid_idx      = retire_tid[IW-1:0];
  assign commit_idx   = commit_q[IW-1:0];
  // Bound check guards the index once the watermark has passed max_q
  assign commit_hit   = (commit_q <= max_q) && bitmap_q[commit_idx];

  always_comb begin
    state_d  = state_q;
    bitmap_d = bitmap_q;
    max_d    = max_q;
    count_d  = count_q;
    commit_d = commit_q;
    done_d   = done_q;
    dup_d    = dup_q;
    range_d  = range_q;
    if (clr) begin
      state_d  = StIdle;
      bitmap_d = '0;
      count_d  = '0;
      commit_d = '0;
      done_d   = 1'b0;
      dup_d    = 1'b0;
      range_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_d = StActive;
            if (max_tid >= TW'(TOTAL_TID)) begin
              max_d   = MaxLegal;
              range_d = 1'b1;
            end else begin
              max_d = max_tid;
            end
          end
        end
        StActive, StDone: begin
          if (commit_hit) begin
            commit_d = commit_q + TW'(1);
          end
          if (accept) begin
            if (retire_tid > max_q) begin
              range_d = 1'b1;
            end else if (bitmap_q[tid_idx]) begin
              dup_d = 1'b1;
            end else begin
              bitmap_d[tid_idx] = 1'b1;
              count_d           = count_q + TW'(1);
              if (count_q == max_q) begin
                state_d = StDone;
                done_d  = 1'b1;
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      bitmap_q <= '0;
      max_q    <= '0;
      count_q  <= '0;
      commit_q <= '0;
      done_q   <= 1'b0;
      dup_q    <= 1'b0;
      range_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      max_q    <= max_d;
      count_q  <= count_d;
      commit_q <= commit_d;
      done_q   <= done_d;
      dup_q    <= dup_d;
      range_q  <= range_d;
    end
  end

  assign retired_count = count_q;
  assign commit_tid    = commit_q;
  assign done          = done_q;
  assign dup_err       = dup_q;
  assign range_err     = range_q;

`ifdef RETIRE_TIMEOUT_EN
  logic [31:0] idle_q, idle_d;
  logic        timeout_q, timeout_d;

  always_comb begin
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (clr) begin
      idle_d    = '0;
      timeout_d = 1'b0;
    end else if (state_q != StActive) begin
      idle_d = '0;
    end else if (enable) begin
      if (accept) begin
        idle_d = '0;
      end else if (idle_q != '1) begin
        idle_d = idle_q + 32'd1;
      end
      if (idle_d >= TIMEOUT_CYCLES) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  // Watchdog not built; parameter kept so both builds share one interface
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tid_retire_tracker.sv
// Self-checking bench for tid_retire_tracker: directed scenarios plus randomized launches
// compared against a set/counter reference model.
module tb_tid_retire_tracker;

  localparam int TOTAL = 512;
  localparam int TMO   = 16;
  localparam int TW    = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          clr = 1'b0;
  logic [TW-1:0] max_tid = '0;
  logic          retire_valid = 1'b0;
  logic [TW-1:0] retire_tid = '0;
  logic          retire_ready;
  logic [TW-1:0] retired_count;
  logic [TW-1:0] commit_tid;
  logic          done;
  logic          dup_err;
  logic          range_err;
  logic          timeout;

  int n_tests = 0;
  int n_fail  = 0;

  tid_retire_tracker #(
    .TOTAL_TID     (TOTAL),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .clr          (clr),
    .max_tid      (max_tid),
    .retire_valid (retire_valid),
    .retire_tid   (retire_tid),
    .retire_ready (retire_ready),
    .retired_count(retired_count),
    .commit_tid   (commit_tid),
    .done         (done),
    .dup_err      (dup_err),
    .range_err    (range_err),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: set of retired TIDs, counters and sticky flags
  bit m_seen[TOTAL];
  int m_max, m_count, m_commit, m_idle;
  bit m_active, m_finished, m_done, m_dup, m_range, m_to;

  task automatic model_reset();
    for (int i = 0; i < TOTAL; i++) m_seen[i] = 1'b0;
    m_max = 0; m_count = 0; m_commit = 0; m_idle = 0;
    m_active = 0; m_finished = 0; m_done = 0; m_dup = 0; m_range = 0; m_to = 0;
  endtask

  task automatic model_edge();
    int nc;
    bit acc;
    if (clr) begin
      model_reset();
      return;
    end
    if (!m_active && !m_finished) begin
      if (enable) begin
        m_active = 1;
        if (int'(max_tid) >= TOTAL) begin
          m_max = TOTAL - 1;
          m_range = 1;
        end else begin
          m_max = int'(max_tid);
        end
      end
      return;
    end
    nc = m_commit;
    if (m_commit <= m_max && m_seen[m_commit]) nc = m_commit + 1;
    acc = m_active && enable && retire_valid;
    if (m_active && enable) begin
      m_idle = acc ? 0 : m_idle + 1;
`ifdef RETIRE_TIMEOUT_EN
      if (m_idle >= TMO) m_to = 1;
`endif
    end
    if (acc) begin
      if (int'(retire_tid) > m_max) m_range = 1;
      else if (m_seen[retire_tid]) m_dup = 1;
      else begin
        m_seen[retire_tid] = 1;
        m_count++;
        if (m_count == m_max + 1) begin
          m_active = 0;
          m_finished = 1;
          m_done = 1;
        end
      end
    end
    m_commit = nc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_clear();
    clr = 1; enable = 0; retire_valid = 0;
    tick();
    clr = 0;
  endtask

  task automatic launch(input int mt);
    max_tid = TW'(mt);
    enable = 1;
    tick();
  endtask

  task automatic retire(input int t);
    retire_valid = 1;
    retire_tid = TW'(t);
    tick();
    retire_valid = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    model_reset();
    n_tests++; if (retired_count !== 0) begin n_fail++; $display("FAIL reset_count got %0d want 0", retired_count); end
    n_tests++; if (commit_tid !== 0) begin n_fail++; $display("FAIL reset_commit got %0d want 0", commit_tid); end
    n_tests++; if ({done, dup_err, range_err, timeout, retire_ready} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags got %b want 00000", {done, dup_err, range_err, timeout, retire_ready});
    end
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_in_order();
    do_clear();
    launch(7);
    n_tests++; if (retire_ready !== 1'b1) begin n_fail++; $display("FAIL inorder_ready got %b want 1", retire_ready); end
    for (int i = 0; i < 7; i++) retire(i);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL inorder_early_done got %b want 0", done); end
    retire(7);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL inorder_done got %b want 1", done); end
    n_tests++; if (retired_count !== 8) begin n_fail++; $display("FAIL inorder_count got %0d want 8", retired_count); end
    n_tests++; if (retire_ready !== 1'b0) begin n_fail++; $display("FAIL inorder_ready_after got %b want 0", retire_ready); end
    tick();
    n_tests++; if (commit_tid !== 8) begin n_fail++; $display("FAIL inorder_commit got %0d want 8", commit_tid); end
    n_tests++; if ({dup_err, range_err} !== 2'b00) begin n_fail++; $display("FAIL inorder_errs got %b want 00", {dup_err, range_err}); end
  endtask

  task automatic test_out_of_order();
    int order[4] = '{3, 1, 2, 0};
    do_clear();
    launch(3);
    for (int i = 0; i < 4; i++) begin
      retire(order[i]);
      n_tests++; if (commit_tid !== 0) begin n_fail++; $display("FAIL ooo_commit_hold[%0d] got %0d want 0", i, commit_tid); end
    end
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ooo_done got %b want 1", done); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_tests++; if (commit_tid !== TW'(k)) begin n_fail++; $display("FAIL ooo_commit_step got %0d want %0d", commit_tid, k); end
    end
  endtask

  task automatic test_errors();
    do_clear();
    launch(5);
    retire(2);
    retire(2);
    n_tests++; if (dup_err !== 1'b1) begin n_fail++; $display("FAIL err_dup got %b want 1", dup_err); end
    n_tests++; if (range_err !== 1'b0) begin n_fail++; $display("FAIL err_range_early got %b want 0", range_err); end
    retire(9);
    n_tests++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL err_range got %b want 1", range_err); end
    n_tests++; if (retired_count !== 1) begin n_fail++; $display("FAIL err_count got %0d want 1", retired_count); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL err_done got %b want 0", done); end
  endtask

  task automatic test_clr_mid();
    do_clear();
    launch(7);
    for (int i = 0; i < 3; i++) retire(i);
    clr = 1; retire_valid = 1; retire_tid = 3;
    tick();
    clr = 0; retire_valid = 0;
    n_tests++; if (retired_count !== 0) begin n_fail++; $display("FAIL clr_count got %0d want 0", retired_count); end
    n_tests++; if (commit_tid !== 0) begin n_fail++; $display("FAIL clr_commit got %0d want 0", commit_tid); end
    n_tests++; if ({done, dup_err, range_err, timeout, retire_ready} !== 5'b0) begin
      n_fail++; $display("FAIL clr_flags got %b want 00000", {done, dup_err, range_err, timeout, retire_ready});
    end
    launch(1);
    retire(0);
    retire(1);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL clr_relaunch_done got %b want 1", done); end
    n_tests++; if (retired_count !== 2) begin n_fail++; $display("FAIL clr_relaunch_count got %0d want 2", retired_count); end
  endtask

  task automatic test_async_reset();
    do_clear();
    launch(7);
    retire(0);
    retire(1);
    rst_n = 0;
    #1;
    n_tests++; if (retired_count !== 0) begin n_fail++; $display("FAIL areset_count got %0d want 0", retired_count); end
    n_tests++; if (retire_ready !== 1'b0) begin n_fail++; $display("FAIL areset_ready got %b want 0", retire_ready); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_clamp_full();
    do_clear();
    launch(TOTAL);
    n_tests++; if (range_err !== 1'b1) begin n_fail++; $display("FAIL clamp_range got %b want 1", range_err); end
    for (int i = 0; i < TOTAL - 1; i++) retire(i);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL clamp_early_done got %b want 0", done); end
    retire(TOTAL - 1);
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL clamp_done got %b want 1", done); end
    n_tests++; if (retired_count !== TW'(TOTAL)) begin n_fail++; $display("FAIL clamp_count got %0d want %0d", retired_count, TOTAL); end
    tick();
    n_tests++; if (commit_tid !== TW'(TOTAL)) begin n_fail++; $display("FAIL clamp_commit got %0d want %0d", commit_tid, TOTAL); end
  endtask

  task automatic test_timeout();
    logic exp;
`ifdef RETIRE_TIMEOUT_EN
    exp = 1'b1;
`else
    exp = 1'b0;
`endif
    do_clear();
    launch(7);
    retire(0);
    repeat (TMO - 1) tick();
    n_tests++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early got %b want 0", timeout); end
    tick();
    n_tests++; if (timeout !== exp) begin n_fail++; $display("FAIL timeout_flag got %b want %b", timeout, exp); end
    n_tests++; if (retire_ready !== 1'b1) begin n_fail++; $display("FAIL timeout_active got %b want 1", retire_ready); end
  endtask

  task automatic test_random();
    int unseen[$];
    int r;
    for (int l = 0; l < 6; l++) begin
      do_clear();
      launch(l == 0 ? 0 : $urandom_range(1, 30));
      for (int cyc = 0; cyc < 300 && !m_done; cyc++) begin
        enable = ($urandom_range(0, 9) != 0);
        retire_valid = ($urandom_range(0, 3) != 0);
        r = $urandom_range(0, 9);
        unseen.delete();
        for (int t = 0; t <= m_max; t++) if (!m_seen[t]) unseen.push_back(t);
        if (r == 0) retire_tid = TW'(m_max + 1 + $urandom_range(0, 20));
        else if (r == 1 || unseen.size() == 0) retire_tid = TW'($urandom_range(0, m_max));
        else retire_tid = TW'(unseen[$urandom_range(0, unseen.size() - 1)]);
        tick();
        n_tests++; if (retired_count !== TW'(m_count)) begin n_fail++; $display("FAIL rnd_count got %0d want %0d", retired_count, m_count); end
        n_tests++; if (commit_tid !== TW'(m_commit)) begin n_fail++; $display("FAIL rnd_commit got %0d want %0d", commit_tid, m_commit); end
        n_tests++; if (done !== m_done) begin n_fail++; $display("FAIL rnd_done got %b want %b", done, m_done); end
        n_tests++; if (dup_err !== m_dup) begin n_fail++; $display("FAIL rnd_dup got %b want %b", dup_err, m_dup); end
        n_tests++; if (range_err !== m_range) begin n_fail++; $display("FAIL rnd_range got %b want %b", range_err, m_range); end
        n_tests++; if (timeout !== m_to) begin n_fail++; $display("FAIL rnd_timeout got %b want %b", timeout, m_to); end
        n_tests++; if (retire_ready !== (m_active && enable)) begin
          n_fail++; $display("FAIL rnd_ready got %b want %b", retire_ready, m_active && enable);
        end
      end
      retire_valid = 0;
      repeat (3) tick();
      n_tests++; if (commit_tid !== TW'(m_commit)) begin n_fail++; $display("FAIL rnd_commit_tail got %0d want %0d", commit_tid, m_commit); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_in_order();
    test_out_of_order();
    test_errors();
    test_clr_mid();
    test_async_reset();
    test_clamp_full();
    test_timeout();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tid_retire_tracker.md
Name: tid_retire_tracker

Overview:
- Receive-side counterpart of the CGRA thread dispatcher.
- Collects per-thread retirement notifications from the CGRA pipeline. These arrive in any order, one per cycle.
- Records each retired TID in a bitmap and tracks the contiguous in-order commit watermark.
- Asserts done once every TID 0..max_tid has retired exactly once. The CGRA subsystem uses done to end the kernel launch.

Parameters:
- TOTAL_TID, 512, bitmap depth; legal TIDs are 0..TOTAL_TID-1.
- TIMEOUT_CYCLES, 1024, idle-cycle limit for the watchdog (used only with RETIRE_TIMEOUT_EN).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  start/continue tracking; sampled in IDLE to latch max_tid
- clr  input  1  synchronous clear to IDLE; priority over enable
- max_tid  input  TW=$clog2(TOTAL_TID+1)  last TID of the launch (inclusive)
- retire_valid  input  1  retirement notification valid
- retire_tid  input  TW  TID being retired
- retire_ready  output  1  tracker accepts a notification this cycle
- retired_count  output  TW  number of distinct TIDs accepted
- commit_tid  output  TW  lowest TID not yet retired (in-order watermark)
- done  output  1  all TIDs 0..max_tid retired
- dup_err  output  1  sticky: a TID retired twice
- range_err  output  1  sticky: retire_tid > latched max, or max_tid clamped
- timeout  output  1  sticky watchdog flag (0 without RETIRE_TIMEOUT_EN)

Behaviour:
- Reset (rst_n low, async): state=IDLE; bitmap all 0; all outputs 0; max_q=0.
- States: IDLE, ACTIVE, DONE.
- IDLE:
  - retire_ready=0.
  - If enable && !clr: latch max_q=max_tid and go to ACTIVE.
  - If max_tid >= TOTAL_TID: max_q=TOTAL_TID-1 and set range_err.
- ACTIVE:
  - retire_ready=1 combinationally.
  - Accept when retire_valid && retire_ready.
  - Accepted TID > max_q: set range_err; bitmap and count unchanged.
  - Accepted TID whose bitmap bit is already set: set dup_err; nothing else changes.
  - Otherwise: set the bit; retired_count += 1 on the next edge.
  - When an accept brings the count to max_q+1: go to DONE and assert done on the same edge. done is visible the cycle after the final accept.
- Watermark: commit_tid advances by at most 1 per cycle while bitmap[commit_tid]=1 and commit_tid <= max_q. It lags a burst of retirements and catches up one TID per cycle. It saturates at max_q+1. It advances in both ACTIVE and DONE.
- DONE:
  - retire_ready=0; done holds 1.
  - Stays until clr; enable is ignored.
- clr (any state, clr has priority): on the next edge go to IDLE and zero the bitmap, retired_count, commit_tid, done, dup_err, range_err and timeout. Clearing the bitmap happens in one cycle.
- enable low in ACTIVE: retire_ready=0 (tracking is paused); state and flags hold.
- max_tid=0: a single retire of TID 0 completes the launch.
- Simultaneous clr and retire_valid: clr wins and the notification is dropped.
- Reset mid-operation: returns to reset values immediately, regardless of clk.

Optional Feature:
- RETIRE_TIMEOUT_EN defined:
  - A 32-bit idle counter runs in ACTIVE with enable=1. It resets on any accept.
  - When the counter reaches TIMEOUT_CYCLES, timeout is set (sticky until clr or reset). The state does not change.
  - The counter is held at 0 outside ACTIVE.
- Not defined: no counter logic; timeout is tied to 0.

Test Plan:
- Reset, then enable with max_tid=7; retire TIDs 0..7 in order, one per cycle -> retired_count=8, done=1 the cycle after TID 7, retire_ready=0 afterwards, commit_tid=8, no errors.
- max_tid=3; retire TIDs 3,1,2,0 -> commit_tid stays 0 until TID 0 retires, then steps 1,2,3,4 on consecutive cycles; done=1 after the fourth accept.
- max_tid=5; retire 2, 2, 9 -> dup_err=1 after the second 2, range_err=1 after 9, retired_count=1, done=0.
- Mid-launch (3 of 8 retired), assert clr together with retire_valid -> next cycle IDLE, all counts and flags 0, the notification is not counted. Re-enable with max_tid=1, retire 0 and 1 -> done=1.
- enable with max_tid=TOTAL_TID (512) -> range_err=1, max_q=511; retiring all 512 TIDs gives done=1.
- With RETIRE_TIMEOUT_EN and TIMEOUT_CYCLES=16: enable, retire once, then idle 16 cycles -> timeout=1 while still ACTIVE. Without the macro, the same stimulus leaves timeout=0.
